// File: rtl/sym_fir_tdm.sv
// Symmetric odd-length FIR filter, time-multiplexed over one pre-adder,
// one multiplier and one accumulator. Each accepted sample takes K MAC
// cycles plus one rounding cycle; only the K unique coefficients are stored.
module sym_fir_tdm #(
  parameter int DATA_W    = 18,
  parameter int COEF_W    = 18,
  parameter int NTAPS     = 129,
  parameter int ACC_W     = 44,
  parameter int OUT_SHIFT = 17
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   clk_en,
  input  logic signed [DATA_W-1:0]               x_in,
  input  logic                                   coef_we,
  input  logic [$clog2((NTAPS+1)/2)-1:0]         coef_addr,
  input  logic signed [COEF_W-1:0]               coef_data,
  input  logic                                   err_clr,
  output logic signed [DATA_W-1:0]               y,
  output logic                                   y_valid,
  output logic                                   busy,
  output logic                                   overrun,
  output logic                                   coef_wr_ign
);

  localparam int K      = (NTAPS + 1) / 2;
  localparam int AW     = $clog2(K);
  localparam int TAP_W  = $clog2(NTAPS);
  localparam int PRE_W  = DATA_W + 1;
  localparam int PROD_W = PRE_W + COEF_W;

  // Rounding constant 2^(OUT_SHIFT-1), or zero when OUT_SHIFT is 0.
  localparam logic signed [ACC_W:0] RND =
    ({{ACC_W{1'b0}}, 1'b1} << OUT_SHIFT) >> 1;

  // Output clamp limits, expressed at the widened accumulator width.
  localparam logic signed [ACC_W:0] YMAX_EXT =
    {{(ACC_W + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] YMIN_EXT =
    {{(ACC_W + 2 - DATA_W){1'b1}}, {(DATA_W - 1){1'b0}}};
  localparam logic signed [DATA_W-1:0] YMAX = {1'b0, {(DATA_W - 1){1'b1}}};
  localparam logic signed [DATA_W-1:0] YMIN = {1'b1, {(DATA_W - 1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    ROUND
  } state_t;

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] dly_q  [NTAPS];
  logic signed [COEF_W-1:0] coef_q [K];

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [AW-1:0]            idx_q, idx_d;
  logic signed [DATA_W-1:0] y_q, y_d;
  logic                     y_valid_q, y_valid_d;
  logic                     overrun_q, overrun_d;
  logic                     coef_wr_ign_q, coef_wr_ign_d;

  logic                     idle;
  logic                     accept;
  logic                     last_tap;
  logic                     addr_ok;
  logic                     coef_wr;

  logic [TAP_W-1:0]         tap_a, tap_b;
  logic signed [DATA_W-1:0] samp_a, samp_b;
  logic signed [PRE_W-1:0]  pre_sum;
  logic signed [COEF_W-1:0] coef_sel;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;

  logic signed [ACC_W:0]    acc_ext;
  logic signed [ACC_W:0]    rnd_sum;
  logic signed [ACC_W:0]    shifted;
  logic signed [DATA_W-1:0] y_sat;

  assign idle     = (state_q == IDLE);
  assign accept   = idle && clk_en;
  assign last_tap = (idx_q == AW'(K - 1));
  assign addr_ok  = ({1'b0, coef_addr} < (AW + 1)'(K));
  assign coef_wr  = idle && coef_we && addr_ok;

  // Datapath: pick the mirrored tap pair, pre-add, multiply, widen.
  always_comb begin
    tap_a    = TAP_W'(idx_q);
    tap_b    = TAP_W'(NTAPS - 1) - tap_a;
    samp_a   = dly_q[tap_a];
    samp_b   = dly_q[tap_b];
    coef_sel = coef_q[idx_q];
    // The centre tap has no partner, so it enters the multiplier alone.
    if (last_tap) begin
      pre_sum = {samp_a[DATA_W-1], samp_a};
    end else begin
      pre_sum = {samp_a[DATA_W-1], samp_a} + {samp_b[DATA_W-1], samp_b};
    end
    prod     = pre_sum * coef_sel;
    prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
  end

  // Output stage: round half up, arithmetic shift, then clamp to DATA_W.
  always_comb begin
    acc_ext = {acc_q[ACC_W-1], acc_q};
    rnd_sum = acc_ext + RND;
    shifted = rnd_sum >>> OUT_SHIFT;
    if (shifted > YMAX_EXT) begin
      y_sat = YMAX;
    end else if (shifted < YMIN_EXT) begin
      y_sat = YMIN;
    end else begin
      y_sat = shifted[DATA_W-1:0];
    end
  end

  // Next-state logic for the sequencer, accumulator, output and sticky flags.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (clk_en) begin
          state_d = MAC;
          acc_d   = '0;
          idx_d   = '0;
        end
      end
      MAC: begin
        acc_d = acc_q + prod_ext;
        idx_d = idx_q + 1'b1;
        if (last_tap) begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        y_d       = y_sat;
        y_valid_d = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // A set condition in the same cycle as err_clr wins.
    overrun_d     = (overrun_q && !err_clr) || (clk_en && !idle);
    coef_wr_ign_d = (coef_wr_ign_q && !err_clr) || (coef_we && !idle && addr_ok);
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      acc_q         <= '0;
      idx_q         <= '0;
      y_q           <= '0;
      y_valid_q     <= 1'b0;
      overrun_q     <= 1'b0;
      coef_wr_ign_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      idx_q         <= idx_d;
      y_q           <= y_d;
      y_valid_q     <= y_valid_d;
      overrun_q     <= overrun_d;
      coef_wr_ign_q <= coef_wr_ign_d;
    end
  end

  // Sample delay line: shifts only when a sample is accepted in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NTAPS; i++) begin
        dly_q[i] <= '0;
      end
    end else if (accept) begin
      dly_q[0] <= x_in;
      for (int unsigned i = 1; i < NTAPS; i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  // Coefficient store: writable only while idle and with an in-range index.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < K; i++) begin
        coef_q[i] <= '0;
      end
    end else if (coef_wr) begin
      coef_q[coef_addr] <= coef_data;
    end
  end

  assign y           = y_q;
  assign y_valid     = y_valid_q;
  assign busy        = !idle;
  assign overrun     = overrun_q;
  assign coef_wr_ign = coef_wr_ign_q;

endmodule

// File: tb/tb_sym_fir_tdm.sv
// Bench for sym_fir_tdm: NTAPS=7, 18-bit data/coefficients. Two instances
// share the stimulus, one with OUT_SHIFT=0 and one with OUT_SHIFT=2, and
// both are checked against a direct-form convolution model.
module tb_sym_fir_tdm;

  logic               clk;
  logic               reset;
  logic               clk_en;
  logic signed [17:0] x_in;
  logic               coef_we;
  logic [1:0]         coef_addr;
  logic signed [17:0] coef_data;
  logic               err_clr;

  logic signed [17:0] y0, y1;
  logic               y_valid0, y_valid1;
  logic               busy0, busy1;
  logic               overrun0, overrun1;
  logic               coef_wr_ign0, coef_wr_ign1;

  int checks = 0;
  int errors = 0;

  longint hist [7];
  longint cm   [4];
  int     imp  [8] = '{1, 2, 3, 4, 3, 2, 1, 0};

  sym_fir_tdm #(
    .DATA_W(18), .COEF_W(18), .NTAPS(7), .ACC_W(44), .OUT_SHIFT(0)
  ) dut0 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .x_in(x_in),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .err_clr(err_clr), .y(y0), .y_valid(y_valid0), .busy(busy0),
    .overrun(overrun0), .coef_wr_ign(coef_wr_ign0)
  );

  sym_fir_tdm #(
    .DATA_W(18), .COEF_W(18), .NTAPS(7), .ACC_W(44), .OUT_SHIFT(2)
  ) dut1 (
    .clk(clk), .reset(reset), .clk_en(clk_en), .x_in(x_in),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .err_clr(err_clr), .y(y1), .y_valid(y_valid1), .busy(busy1),
    .overrun(overrun1), .coef_wr_ign(coef_wr_ign1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 7; i++) hist[i] = 0;
    for (int i = 0; i < 4; i++) cm[i] = 0;
  endfunction

  function automatic void model_push(input longint x);
    for (int i = 6; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
  endfunction

  // Full 7-tap convolution with mirrored coefficients, then round/shift/clamp.
  function automatic longint model_y(input int s);
    longint sum, r;
    sum = 0;
    for (int t = 0; t < 7; t++) sum += cm[(t < 4) ? t : 6 - t] * hist[t];
    r = (s == 0) ? sum : ((sum + (longint'(1) <<< (s - 1))) >>> s);
    if (r > 131071) r = 131071;
    if (r < -131072) r = -131072;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int a, input longint v);
    coef_we   = 1'b1;
    coef_addr = 2'(a);
    coef_data = 18'(v);
    tick();
    coef_we = 1'b0;
    cm[a] = v;
  endtask

  task automatic load_coefs(input longint c0, input longint c1,
                            input longint c2, input longint c3);
    write_coef(0, c0);
    write_coef(1, c1);
    write_coef(2, c2);
    write_coef(3, c3);
  endtask

  // Strobe one sample and follow it: y_valid must rise exactly 6 edges later.
  task automatic send(input logic signed [17:0] x);
    clk_en = 1'b1;
    x_in   = x;
    tick();
    clk_en = 1'b0;
    model_push(longint'(x));
    chk("busy_after_accept", busy0, 1);
    for (int e = 2; e <= 6; e++) begin
      tick();
      chk("y_valid0_timing", y_valid0, (e == 6));
      chk("y_valid1_timing", y_valid1, (e == 6));
    end
    chk("y_shift0", y0, model_y(0));
    chk("y_shift2", y1, model_y(2));
  endtask

  // Bounded wait for exactly one result pulse of an already accepted sample.
  task automatic wait_one_result(input int n_edges);
    int cnt;
    cnt = 0;
    for (int e = 0; e < n_edges; e++) begin
      tick();
      if (y_valid0) begin
        cnt++;
        chk("y_shift0_wait", y0, model_y(0));
        chk("y_shift2_wait", y1, model_y(2));
      end
    end
    chk("one_pulse", cnt, 1);
  endtask

  initial begin
    logic signed [17:0] xr;
    logic signed [17:0] cr;
    int                 cnt;

    clk_en = 0; x_in = '0; coef_we = 0; coef_addr = '0; coef_data = '0;
    err_clr = 0; reset = 1;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_y0", y0, 0);
    chk("rst_y1", y1, 0);
    chk("rst_y_valid0", y_valid0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_overrun0", overrun0, 0);
    chk("rst_coef_wr_ign0", coef_wr_ign0, 0);
    reset = 0;
    tick();

    // Impulse response.
    load_coefs(1, 2, 3, 4);
    for (int i = 0; i < 8; i++) begin
      send((i == 0) ? 18'sd1 : 18'sd0);
      chk("impulse_table", y0, imp[i]);
    end

    // Saturation at both rails.
    load_coefs(0, 0, 0, 131071);
    repeat (4) send(18'sd100);
    chk("sat_pos", y0, 131071);
    repeat (4) send(-18'sd100);
    chk("sat_neg", y0, -131072);

    // Rounding with OUT_SHIFT=2 on the centre tap.
    load_coefs(0, 0, 0, 1);
    repeat (4) send(18'sd6);
    chk("round_p6", y1, 2);
    repeat (4) send(-18'sd6);
    chk("round_m6", y1, -1);
    repeat (4) send(18'sd5);
    chk("round_p5", y1, 1);

    // Overrun and ignored coefficient write while busy.
    load_coefs(1, 2, 3, 4);
    clk_en = 1; x_in = 18'sd7;
    tick();
    clk_en = 0;
    model_push(7);
    tick();
    clk_en = 1; x_in = 18'sd99; coef_we = 1; coef_addr = 2'd0; coef_data = 18'sd9;
    tick();
    clk_en = 0; coef_we = 0;
    chk("overrun_set", overrun0, 1);
    chk("coef_wr_ign_set", coef_wr_ign0, 1);
    chk("overrun_set_dut1", overrun1, 1);
    wait_one_result(10);
    send(18'sd0);

    // err_clr coinciding with a new overrun: overrun stays, write flag clears.
    clk_en = 1; x_in = 18'sd3;
    tick();
    model_push(3);
    err_clr = 1;
    tick();
    clk_en = 0; err_clr = 0;
    chk("clr_vs_set_overrun", overrun0, 1);
    chk("clr_coef_wr_ign", coef_wr_ign0, 0);
    wait_one_result(8);
    err_clr = 1;
    tick();
    err_clr = 0;
    chk("clr_overrun", overrun0, 0);
    chk("clr_coef_wr_ign_again", coef_wr_ign0, 0);

    // Randomized samples and coefficient sets, with occasional idle gaps.
    for (int i = 0; i < 40; i++) begin
      if (i % 10 == 0) begin
        for (int a = 0; a < 4; a++) begin
          cr = 18'($urandom);
          write_coef(a, longint'(cr));
        end
      end
      repeat ($urandom_range(0, 2)) tick();
      xr = 18'($urandom);
      send(xr);
    end

    // Reset two cycles after a strobe aborts the computation.
    clk_en = 1; x_in = 18'sd5;
    tick();
    clk_en = 0;
    tick();
    reset = 1;
    tick();
    reset = 0;
    model_clear();
    cnt = 0;
    for (int e = 0; e < 8; e++) begin
      if (y_valid0 || y_valid1) cnt++;
      tick();
    end
    chk("abort_no_pulse", cnt, 0);
    chk("abort_y0", y0, 0);
    chk("abort_y1", y1, 0);
    chk("abort_busy", busy0, 0);
    load_coefs(1, 2, 3, 4);
    for (int i = 0; i < 8; i++) begin
      send((i == 0) ? 18'sd1 : 18'sd0);
      chk("impulse_after_reset", y0, imp[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
